map_port_arbiter: RTL and testbench

Arbitrates the single read port of the 128x128 world map memory between the video path and the bot/CPU map-lookup requester. The video path presents the scaled map address every pixel clock. A read is issued only when that address changes (once per 8 display columns), which leaves most slots free for the bot requester. A starvation guard bounds bot wait time. The block sits between the display scaler, the world map memory and the bot interface, all in the pixel clock domain.

---
 rtl/map_port_arbiter.sv | 121 ++++++++++++
 tb/tb_map_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the world map read port between the video scan
// path and the bot lookup requester. Video reads only when its scaled address
// changes; a bot that waits STARVE_MAX cycles is given the slot ahead of video.
module map_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 2,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_active,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_miss,
    input  logic [ADDR_W-1:0] bot_addr,
    input  logic              bot_req,
    output logic              bot_ack,
    output logic [DATA_W-1:0] bot_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VID  = 2'd1;
    localparam logic [1:0] TAG_BOT  = 2'd2;

    logic [ADDR_W-1:0] last_vid_addr;
    logic              last_valid;
    logic              bot_busy;
    logic [CNT_W-1:0]  starve_cnt;
    logic [1:0]        tag;

    logic vid_need;
    logic bot_pend;
    logic starved;
    logic vid_issue;
    logic bot_issue;

    assign vid_need  = vid_active && (!last_valid || (vid_addr != last_vid_addr));
    // bot_busy drops on the edge that raises bot_ack, but the requester still
    // holds bot_req through the ack cycle; that cycle is not a new request.
    assign bot_pend  = bot_req && !bot_busy && !bot_ack;
    assign starved   = (starve_cnt >= CNT_W'(STARVE_MAX));
    assign vid_issue = vid_need && !(bot_pend && starved);
    assign bot_issue = !vid_issue && bot_pend;

    // Slot decision drives the memory port; nothing is issued while in reset.
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        if (!reset) begin
            if (vid_issue) begin
                mem_en   = 1'b1;
                mem_addr = vid_addr;
            end else if (bot_issue) begin
                mem_en   = 1'b1;
                mem_addr = bot_addr;
            end
        end
    end

    // Video address tracking: remember the last issued address while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_vid_addr <= '0;
            last_valid    <= 1'b0;
            vid_miss      <= 1'b0;
        end else begin
            vid_miss <= vid_need && bot_issue;
            if (!vid_active) begin
                last_valid <= 1'b0;
            end else if (vid_issue) begin
                last_valid    <= 1'b1;
                last_vid_addr <= vid_addr;
            end
        end
    end

    // Starvation counter: counts bot cycles lost to video, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bot_issue) begin
            starve_cnt <= '0;
        end else if (bot_pend && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Return tag and data steering; a reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag      <= TAG_NONE;
            bot_busy <= 1'b0;
            bot_ack  <= 1'b0;
            bot_data <= '0;
            vid_data <= '0;
        end else begin
            bot_ack <= 1'b0;
            if (vid_issue)      tag <= TAG_VID;
            else if (bot_issue) tag <= TAG_BOT;
            else                tag <= TAG_NONE;

            if (bot_issue)           bot_busy <= 1'b1;
            else if (tag == TAG_BOT) bot_busy <= 1'b0;

            case (tag)
                TAG_VID: vid_data <= mem_dout;
                TAG_BOT: begin
                    bot_data <= mem_dout;
                    bot_ack  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Bench for map_port_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model (pending reads in a latency queue).
module tb_map_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 2;
    localparam int SM = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_active = 1'b0;
    logic [DW-1:0] vid_data;
    logic          vid_miss;
    logic [AW-1:0] bot_addr = '0;
    logic          bot_req = 1'b0;
    logic          bot_ack;
    logic [DW-1:0] bot_data;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [DW-1:0] mem_dout = '0;

    int n_cmp = 0;
    int n_err = 0;

    map_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .vid_addr(vid_addr), .vid_active(vid_active),
        .vid_data(vid_data), .vid_miss(vid_miss),
        .bot_addr(bot_addr), .bot_req(bot_req),
        .bot_ack(bot_ack), .bot_data(bot_data),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // World map memory: one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

    // ---------------- reference model ----------------
    typedef struct {int due; bit is_bot; logic [DW-1:0] d;} ret_t;
    ret_t          rq[$];
    int            cyc = 0;
    logic [AW-1:0] m_last = '0;
    bit            m_have = 0, m_bot_out = 0;
    int            m_wait = 0;
    logic [DW-1:0] e_vid_data = '0, e_bot_data = '0;
    bit            e_bot_ack = 0, e_vid_miss = 0;
    bit            need_c, pend_c;
    int            pick_c;

    function automatic bit m_need();
        return vid_active && (!m_have || vid_addr != m_last);
    endfunction
    function automatic bit m_pend();
        return bot_req && !m_bot_out;
    endfunction
    // 0 = idle slot, 1 = video read, 2 = bot read
    function automatic int m_pick();
        if (m_need() && !(m_pend() && m_wait >= SM)) return 1;
        if (m_pend()) return 2;
        return 0;
    endfunction
    function automatic logic [AW:0] exp_mem();
        if (reset) return '0;
        case (m_pick())
            1: return {1'b1, vid_addr};
            2: return {1'b1, bot_addr};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        need_c = m_need();
        pend_c = m_pend();
        pick_c = m_pick();
        if (reset) begin
            rq.delete();
            m_have = 0; m_bot_out = 0; m_wait = 0; m_last = '0;
            e_vid_data = '0; e_bot_data = '0; e_bot_ack = 0; e_vid_miss = 0;
            cyc++;
        end else begin
            if (e_bot_ack) m_bot_out = 0;
            e_bot_ack  = 0;
            e_vid_miss = need_c && (pick_c == 2);
            if (pick_c == 1) begin
                m_last = vid_addr; m_have = 1;
                rq.push_back('{cyc + 2, 1'b0, mem[vid_addr]});
            end else if (pick_c == 2) begin
                m_bot_out = 1;
                rq.push_back('{cyc + 2, 1'b1, mem[bot_addr]});
            end
            if (!vid_active) m_have = 0;
            if (pick_c == 2) m_wait = 0;
            else if (pend_c && m_wait < SM) m_wait++;
            cyc++;
            while (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].is_bot) begin e_bot_data = rq[0].d; e_bot_ack = 1; end
                else e_vid_data = rq[0].d;
                void'(rq.pop_front());
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; vid_active = 0; bot_req = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vid_data, vid_miss, bot_ack, bot_data, mem_en} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %b want 0", {vid_data, vid_miss, bot_ack, bot_data, mem_en});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_video_scan();
        int pulses = 0;
        vid_active = 1; vid_addr = 14'h0005;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) vid_addr = 14'h0006;
            @(negedge clk);
            pulses += int'(mem_en);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++; $display("FAIL scan_model cyc%0d: en=%b addr=%h vd=%h", i, mem_en, mem_addr, vid_data);
            end
            if (i == 2) begin
                n_cmp++;
                if (vid_data !== mem[5]) begin n_err++; $display("FAIL scan_data5: got %h want %h", vid_data, mem[5]); end
            end
            if (i == 10) begin
                n_cmp++;
                if (vid_data !== mem[6]) begin n_err++; $display("FAIL scan_data6: got %h want %h", vid_data, mem[6]); end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses != 2) begin n_err++; $display("FAIL scan_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_bot_idle();
        vid_active = 0; bot_addr = 14'h3F80; bot_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++; $display("FAIL bot_model cyc%0d: en=%b ack=%b", i, mem_en, bot_ack);
            end
            n_cmp++;
            case (i)
                0, 3: if (!(mem_en === 1'b1 && mem_addr === 14'h3F80)) begin
                    n_err++; $display("FAIL bot_issue cyc%0d: en=%b addr=%h want 1/3f80", i, mem_en, mem_addr); end
                1, 4: if (mem_en !== 1'b0 || bot_ack !== 1'b0) begin
                    n_err++; $display("FAIL bot_gap cyc%0d: en=%b ack=%b want 0/0", i, mem_en, bot_ack); end
                default: if (!(bot_ack === 1'b1 && bot_data === mem[14'h3F80] && mem_en === 1'b0)) begin
                    n_err++; $display("FAIL bot_ack cyc%0d: ack=%b data=%h en=%b want 1/%h/0", i, bot_ack, bot_data, mem_en, mem[14'h3F80]); end
            endcase
            @(posedge clk); #1;
        end
        bot_req = 0;
    endtask

    task automatic test_collision();
        logic [AW-1:0] a2, b;
        a2 = 14'h0100 + 14'($urandom_range(0, 255));
        b  = 14'($urandom);
        vid_active = 1; vid_addr = 14'h0020;
        repeat (3) begin @(posedge clk); #1; end
        vid_addr = a2; bot_addr = b; bot_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++; $display("FAIL coll_model cyc%0d: en=%b addr=%h", i, mem_en, mem_addr);
            end
            if (i == 0) begin
                n_cmp++;
                if (!(mem_en === 1'b1 && mem_addr === a2)) begin n_err++; $display("FAIL coll_vid_first: addr=%h want %h", mem_addr, a2); end
            end
            if (i == 1) begin
                n_cmp++;
                if (!(mem_en === 1'b1 && mem_addr === b)) begin n_err++; $display("FAIL coll_bot_next: addr=%h want %h", mem_addr, b); end
            end
            if (i == 3) begin
                n_cmp++;
                if (!(bot_ack === 1'b1 && bot_data === mem[b])) begin n_err++; $display("FAIL coll_ack3: ack=%b data=%h want 1/%h", bot_ack, bot_data, mem[b]); end
            end
            @(posedge clk); #1;
            if (i == 3) bot_req = 0;
        end
    endtask

    task automatic test_starve();
        logic [AW-1:0] base;
        int issue_at = -1, misses = 0, ack_at = -1;
        bit caught = 0;
        base = 14'h1000 + 14'($urandom_range(0, 14'hFFF));
        vid_active = 1; bot_addr = 14'h3FFF; bot_req = 1;
        for (int i = 0; i < SM + 6; i++) begin
            vid_addr = base + 14'(i);
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++; $display("FAIL starve_model cyc%0d: en=%b addr=%h miss=%b", i, mem_en, mem_addr, vid_miss);
            end
            if (issue_at < 0 && mem_en && mem_addr == 14'h3FFF) issue_at = i;
            if (issue_at >= 0 && i == issue_at + 1) caught = mem_en && (mem_addr == vid_addr);
            if (vid_miss) misses++;
            if (bot_ack && ack_at < 0) ack_at = i;
            @(posedge clk); #1;
            if (ack_at >= 0) bot_req = 0;
        end
        n_cmp++;
        if (issue_at != SM) begin n_err++; $display("FAIL starve_issue: got cyc %0d want %0d", issue_at, SM); end
        n_cmp++;
        if (misses != 1) begin n_err++; $display("FAIL starve_miss_count: got %0d want 1", misses); end
        n_cmp++;
        if (!caught) begin n_err++; $display("FAIL starve_catchup: got 0 want 1"); end
        n_cmp++;
        if (ack_at != SM + 2) begin n_err++; $display("FAIL starve_ack: got cyc %0d want %0d", ack_at, SM + 2); end
    endtask

    task automatic test_reset_midread();
        logic [AW-1:0] x;
        x = 14'($urandom);
        vid_active = 0; bot_addr = x; bot_req = 1;
        for (int i = 0; i < 5; i++) begin
            reset = (i == 1);
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++; $display("FAIL rst_model cyc%0d: en=%b ack=%b", i, mem_en, bot_ack);
            end
            if (i == 2) begin
                n_cmp++;
                if ({vid_data, vid_miss, bot_ack, bot_data} !== '0 || mem_en !== 1'b1 || mem_addr !== x) begin
                    n_err++; $display("FAIL rst_outputs: got %b en=%b addr=%h want 0/1/%h", {vid_data, vid_miss, bot_ack, bot_data}, mem_en, mem_addr, x);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (bot_ack !== 1'b0) begin n_err++; $display("FAIL rst_no_ack: got %b want 0", bot_ack); end
            end
            if (i == 4) begin
                n_cmp++;
                if (!(bot_ack === 1'b1 && bot_data === mem[x])) begin n_err++; $display("FAIL rst_reserve: ack=%b data=%h want 1/%h", bot_ack, bot_data, mem[x]); end
            end
            @(posedge clk); #1;
        end
        reset = 0; bot_req = 0;
    endtask

    task automatic test_reactivate();
        logic [AW-1:0] a;
        a = 14'($urandom);
        vid_addr = a;
        for (int i = 0; i < 8; i++) begin
            vid_active = !(i == 3 || i == 4);
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++; $display("FAIL react_model cyc%0d: en=%b addr=%h", i, mem_en, mem_addr);
            end
            if (i == 5) begin
                n_cmp++;
                if (!(mem_en === 1'b1 && mem_addr === a)) begin n_err++; $display("FAIL react_reread: en=%b addr=%h want 1/%h", mem_en, mem_addr, a); end
            end
            if (i == 7) begin
                n_cmp++;
                if (vid_data !== mem[a]) begin n_err++; $display("FAIL react_data: got %h want %h", vid_data, mem[a]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        bit saw_ack = 0;
        for (int i = 0; i < 600; i++) begin
            vid_active = ($urandom_range(0, 9) != 0);
            if (((i / 50) % 2) == 1 || $urandom_range(0, 3) == 0) vid_addr = 14'($urandom);
            if (saw_ack) bot_req = 0;
            else if (!bot_req && $urandom_range(0, 2) == 0) begin
                bot_req = 1; bot_addr = 14'($urandom);
            end
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data} !==
                {exp_mem(), e_vid_data, e_vid_miss, e_bot_ack, e_bot_data}) begin
                n_err++;
                $display("FAIL random cyc%0d: got en=%b a=%h vd=%h m=%b ack=%b bd=%h want %b %h %h %b %b %h", i,
                         mem_en, mem_addr, vid_data, vid_miss, bot_ack, bot_data,
                         exp_mem() >> AW, exp_mem() & {1'b0, {AW{1'b1}}}, e_vid_data, e_vid_miss, e_bot_ack, e_bot_data);
            end
            saw_ack = bot_ack;
            @(posedge clk); #1;
        end
        bot_req = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 2'($urandom);
        test_reset();
        test_video_scan();
        test_bot_idle();
        test_collision();
        test_starve();
        test_reset_midread();
        test_reactivate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
